// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter with an N-to-1 flit mux and a one-entry registered output stage.
// With LOCK_EN the grant stays with the winning port until its tail flit has been sent.
module rr_arbiter_mux #(
  parameter int unsigned N       = 5,
  parameter int unsigned W       = 32,
  parameter bit          LOCK_EN = 1'b1,
  parameter int unsigned SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N*W-1:0]  data_i,
  input  logic [N-1:0]    tail_i,
  input  logic            ready_i,
  output logic [N-1:0]    gnt_o,
  output logic [W-1:0]    data_o,
  output logic            tail_o,
  output logic            valid_o,
  output logic [SW-1:0]   sel_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e        r_state;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_owner;
  logic [SW-1:0] r_sel;
  logic          r_valid;
  logic          r_tail;
  logic [W-1:0]  r_data;

  logic [2*N-1:0] w_req2;
  logic [N-1:0]   w_rot;
  logic           w_found;
  logic [SW:0]    w_off;
  logic [SW:0]    w_sum;
  logic [SW-1:0]  w_cand;
  logic [SW-1:0]  w_idx;
  logic [N-1:0]   w_onehot;
  logic           w_elig;
  logic           w_can_load;
  logic           w_xfer;
  logic           w_sel_tail;
  logic [W-1:0]   w_data;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
    if (32'(x) >= N - 1) return '0;
    return x + SW'(1);
  endfunction

  // Rotate requests so that bit 0 is the port at the round-robin pointer.
  assign w_req2 = {req_i, req_i};
  assign w_rot  = N'(w_req2 >> r_ptr);

  // Find the first requester at or after the pointer (lowest rotated offset wins).
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = (SW+1)'(i);
      end
    end
    w_sum  = {1'b0, r_ptr} + w_off;
    w_cand = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N)) : SW'(w_sum);
  end

  // Grant decision: locked owner only, otherwise the round-robin candidate.
  always_comb begin
    w_idx      = (r_state == StLocked) ? r_owner : w_cand;
    w_onehot   = N'(1) << w_idx;
    w_elig     = (r_state == StLocked) ? |(req_i & w_onehot) : w_found;
    w_can_load = !r_valid || ready_i;
    w_xfer     = !rst_i && w_can_load && w_elig;
    gnt_o      = w_onehot & {N{w_xfer}};
    w_sel_tail = |(tail_i & w_onehot);
  end

  // Flit mux: only the selected port's data reaches the output register.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < N; k++) begin
      w_data = w_data | (data_i[k*W +: W] & {W{w_onehot[k]}});
    end
  end

  // Output register, round-robin pointer and packet-lock state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_tail  <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_tail  <= w_sel_tail;
        r_sel   <= w_idx;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        case (r_state)
          StIdle: begin
            r_ptr <= wrap_inc(w_cand);
            if (LOCK_EN && !w_sel_tail) begin
              r_state <= StLocked;
              r_owner <= w_cand;
            end
          end
          StLocked: begin
            // Tail released: previous owner becomes lowest priority.
            if (w_sel_tail) begin
              r_state <= StIdle;
              r_ptr   <= wrap_inc(r_owner);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign data_o  = r_data;
  assign tail_o  = r_tail;
  assign valid_o = r_valid;
  assign sel_o   = r_sel;

endmodule
